// File: rtl/divider_iterative_8b.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, val/rdy streams in and out.
// Optional macro DIVIDER_ZERO_SHORTCUT_EN sends divide-by-zero straight to DONE.
module divider_iterative_8b #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder
);

    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [NBITS:0]   rem_reg;
    logic [NBITS-1:0] quo_reg;
    logic [NBITS-1:0] div_reg;
    logic [CW-1:0]    count;

    logic [NBITS:0]   rem_shift;
    logic [NBITS-1:0] quo_shift;
    logic [NBITS:0]   rem_step;
    logic [NBITS-1:0] quo_step;
    logic             fits;
    logic             last_step;
    logic             in_fire;
    logic             zero_div;

    // A set top bit of R would make the shifted value exceed any divisor, so it forces a subtract.
    always_comb begin
        rem_shift = {rem_reg[NBITS-1:0], quo_reg[NBITS-1]};
        quo_shift = {quo_reg[NBITS-2:0], 1'b0};
        fits      = rem_reg[NBITS] || (rem_shift >= {1'b0, div_reg});
        rem_step  = rem_shift;
        quo_step  = quo_shift;
        if (fits) begin
            rem_step = rem_shift - {1'b0, div_reg};
            quo_step = quo_shift | {{(NBITS-1){1'b0}}, 1'b1};
        end
    end

    assign last_step = (count == CW'(1));
    assign in_fire   = istream_val && istream_rdy;

`ifdef DIVIDER_ZERO_SHORTCUT_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        istream_rdy = (state == IDLE);
        ostream_val = (state == DONE);
        case (state)
            IDLE: begin
                if (in_fire) begin
                    state_next = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers are loaded only when a transaction completes, so they hold across IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg   <= '0;
            quo_reg   <= '0;
            div_reg   <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        quo_reg <= dividend;
                        rem_reg <= '0;
                        div_reg <= divisor;
                        count   <= CW'(NBITS);
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                CALC: begin
                    quo_reg <= quo_step;
                    rem_reg <= rem_step;
                    count   <= count - CW'(1);
                    if (last_step) begin
                        quotient  <= quo_step;
                        remainder <= rem_step[NBITS-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iterative_8b.sv
// Self-checking bench for divider_iterative_8b; a queue scoreboard holds expected (quotient, remainder).
// Latency expectations follow DIVIDER_ZERO_SHORTCUT_EN when it is defined.
module tb_divider_iterative_8b;

    logic       clk;
    logic       reset;
    logic       istream_val;
    logic       istream_rdy;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [7:0] quotient;
    logic [7:0] remainder;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] sb[$];
    logic        busy_rdy_seen;

    divider_iterative_8b #(.NBITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .dividend    (dividend),
        .divisor     (divisor),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand pair through the input handshake and records the expected result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        istream_val = 1'b1;
        dividend    = a;
        divisor     = b;
        while (!istream_rdy && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("istream_rdy_idle", istream_rdy, 1);
        if (b == 8'd0) begin
            exp_q = 8'hFF;
            exp_r = a;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
        end
        sb.push_back({exp_q, exp_r});
        tick();
        istream_val = 1'b0;
        dividend    = 8'($urandom);
        divisor     = 8'($urandom);
    endtask

    // Waits for the result (exp_lat = edges after the handshake, -1 = unchecked), stalls, then retires it.
    task automatic collectResult(input string tag, input int exp_lat, input int stall);
        int lat = 0;
        logic [15:0] exp;
        busy_rdy_seen = 1'b0;
        ostream_rdy = (stall == 0);
        while (!ostream_val && lat < 40) begin
            if (istream_rdy) busy_rdy_seen = 1'b1;
            tick();
            lat++;
        end
        checkOutput({tag, "_val"}, ostream_val, 1);
        if (exp_lat >= 0) checkOutput({tag, "_latency"}, lat, exp_lat);
        if (sb.size() == 0) begin
            checkOutput({tag, "_scoreboard_empty"}, 1, 0);
            exp = 16'hxxxx;
        end else begin
            exp = sb.pop_front();
        end
        checkOutput({tag, "_quotient"}, quotient, exp[15:8]);
        checkOutput({tag, "_remainder"}, remainder, exp[7:0]);
        for (int i = 0; i < stall; i++) begin
            if (istream_rdy) busy_rdy_seen = 1'b1;
            tick();
            checkOutput({tag, "_stall_val"}, ostream_val, 1);
            checkOutput({tag, "_stall_hold"}, {quotient, remainder}, exp);
        end
        if (istream_rdy) busy_rdy_seen = 1'b1;
        ostream_rdy = 1'b1;
        tick();
        ostream_rdy = 1'b0;
        checkOutput({tag, "_busy_rdy_low"}, busy_rdy_seen, 0);
        checkOutput({tag, "_retired_val"}, ostream_val, 0);
        checkOutput({tag, "_retired_rdy"}, istream_rdy, 1);
        checkOutput({tag, "_keep_result"}, {quotient, remainder}, exp);
    endtask

    initial begin
        int zero_lat;
`ifdef DIVIDER_ZERO_SHORTCUT_EN
        zero_lat = 0;
`else
        zero_lat = 8;
`endif
        reset       = 1'b1;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        dividend    = 8'd0;
        divisor     = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_val", ostream_val, 0);
        checkOutput("reset_rdy", istream_rdy, 1);
        checkOutput("reset_outputs", {quotient, remainder}, 16'd0);

        applyStimulus(8'd100, 8'd7);
        collectResult("div_100_7", 8, 0);

        applyStimulus(8'd255, 8'd1);
        collectResult("div_255_1", 8, 0);
        applyStimulus(8'd5, 8'd9);
        collectResult("div_5_9", 8, 0);

        applyStimulus(8'd37, 8'd0);
        collectResult("div_37_0", zero_lat, 0);

        applyStimulus(8'd200, 8'd3);
        collectResult("div_200_3_stall", 8, 3);

        applyStimulus(8'd90, 8'd4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        checkOutput("midreset_val", ostream_val, 0);
        checkOutput("midreset_rdy", istream_rdy, 1);
        checkOutput("midreset_outputs", {quotient, remainder}, 16'd0);
        applyStimulus(8'd90, 8'd4);
        collectResult("div_90_4", 8, 0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom_range(1, 255)));
            collectResult("random", 8, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
